// File: rtl/master_port.sv
// master_port: bus-side initiator for the serial system bus.
//
// Takes one parallel read/write request from a master device, requests the
// bus from the arbiter, shifts the address (and write data) out LSB first,
// and for reads shifts the response back in and returns it in parallel.
// Split responses from the slave pause the read timeout; a slave that never
// answers is caught by the timeout and reported through derr.
//
// Ports
//   clk, rstn        clock (rising edge) and synchronous active-low reset
//   dreq/dmode/daddr/dwdata   device request and its payload
//   dready           port idle, request may be issued
//   ddone/derr       one-cycle completion pulse, derr=1 on read timeout
//   drdata           read data, valid with ddone, held until the next good read
//   mbreq/mbgrant    arbiter request / grant
//   mwdata/mmode/mvalid        serial address/write-data stream to the slave
//   srdata/svalid/sready/ssplit  serial read data and slave status
//   dbg_state        current FSM state, for observation only
//
// Device handshake: a request is taken on a rising edge where dready=1 and
// dreq=1; dmode/daddr/dwdata are sampled on that same edge. dreq while
// dready=0 is ignored (no queueing). Completion is a single-cycle ddone
// pulse; dready returns to 1 in the cycle after ddone.

module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dreq,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic                  ddone,
  output logic                  derr,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit,
  output logic [2:0]            dbg_state
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_sr;   // address, shifted right as bits go out
  logic [DATA_WIDTH-1:0] wdata_sr;  // write data, shifted right as bits go out
  logic [DATA_WIDTH-1:0] rbuf;      // read bits arrive LSB first, enter at the MSB
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tcnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      addr_sr  <= '0;
      wdata_sr <= '0;
      rbuf     <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      dready   <= 1'b1;
      ddone    <= 1'b0;
      derr     <= 1'b0;
      drdata   <= '0;
      mbreq    <= 1'b0;
      mwdata   <= 1'b0;
      mmode    <= 1'b0;
      mvalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq) begin
            mode_q   <= dmode;
            addr_sr  <= daddr;
            wdata_sr <= dwdata;
            mbreq    <= 1'b1;
            dready   <= 1'b0;
            state    <= REQ;
          end
        end

        REQ: begin
          // Grant alone is not enough: the slave must also be idle.
          // Address bit 0 goes out in the cycle right after this edge.
          if (mbgrant && sready) begin
            state   <= ADDR;
            cnt     <= '0;
            tcnt    <= '0;
            mvalid  <= 1'b1;
            mmode   <= mode_q;
            mwdata  <= addr_sr[0];
            addr_sr <= addr_sr >> 1;
          end
        end

        ADDR: begin
          if (cnt == ADDR_LAST) begin
            cnt <= '0;
            if (mode_q) begin
              // Write data follows the address with no gap in mvalid.
              state    <= WDATA;
              mwdata   <= wdata_sr[0];
              wdata_sr <= wdata_sr >> 1;
            end else begin
              state  <= RDATA;
              mvalid <= 1'b0;
              mwdata <= 1'b0;
            end
          end else begin
            cnt     <= cnt + 1'b1;
            mwdata  <= addr_sr[0];
            addr_sr <= addr_sr >> 1;
          end
        end

        WDATA: begin
          if (cnt == DATA_LAST) begin
            state  <= DONE;
            mvalid <= 1'b0;
            mwdata <= 1'b0;
            mbreq  <= 1'b0;
            ddone  <= 1'b1;
            derr   <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            mwdata   <= wdata_sr[0];
            wdata_sr <= wdata_sr >> 1;
          end
        end

        RDATA: begin
          if (svalid) begin
            rbuf <= {srdata, rbuf[DATA_WIDTH-1:1]};
            if (cnt == DATA_LAST) begin
              // drdata only changes on a complete read, so a timeout
              // leaves the previous value visible.
              drdata <= {srdata, rbuf[DATA_WIDTH-1:1]};
              state  <= DONE;
              mbreq  <= 1'b0;
              ddone  <= 1'b1;
              derr   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (!ssplit) begin
            // Idle cycles accumulate over the whole read; split wait only
            // pauses the count, it never clears it.
            tcnt <= tcnt + 1'b1;
            if (tcnt == TO_LAST) begin
              state <= DONE;
              mbreq <= 1'b0;
              ddone <= 1'b1;
              derr  <= 1'b1;
            end
          end
        end

        DONE: begin
          ddone  <= 1'b0;
          derr   <= 1'b0;
          dready <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
